// File: rtl/hex_seg_reader.sv
// hex_seg_reader: samples an active-low 7-segment bus, debounces it, decodes
// each newly accepted pattern back to a hex nibble, flags non-glyph patterns
// and reports the number of cycles between the last two accepted changes.
module hex_seg_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        CLOCK_50,
    input  logic        Reset,
    input  logic [6:0]  seg,
    output logic [3:0]  data,
    output logic        valid,
    output logic        err,
    output logic        changed,
    output logic [27:0] period
);

    localparam logic [3:0]  CNT_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [6:0]  BLANK    = 7'h7F;
    localparam logic [27:0] GAP_MAX  = 28'hFFFFFFF;

    // Active-low glyph patterns (g..a), indexed by the nibble they encode.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [6:0]  s_q_reg;
    logic [6:0]  cand_reg;
    logic [6:0]  acc_reg;
    logic [3:0]  cnt_reg;
    logic [27:0] gap_reg;
    logic [3:0]  data_reg;
    logic        valid_reg;
    logic        err_reg;
    logic        changed_reg;
    logic [27:0] period_reg;

    logic [15:0] match;
    logic        glyph_hit;
    logic [3:0]  glyph_val;
    logic        accept;

    // One comparator per glyph against the current candidate.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign match[gi] = (cand_reg == GLYPH[gi]);
        end
    endgenerate

    // Turn the one-hot glyph match into a nibble.
    always_comb begin
        glyph_hit = |match;
        glyph_val = '0;
        for (int i = 0; i < 16; i++) begin
            if (match[i]) begin
                glyph_val = 4'(i);
            end
        end
    end

    // A candidate that has been stable for the full window and differs from
    // what is already displayed gets accepted on the next edge.
    assign accept = (cnt_reg == CNT_LAST) && (cand_reg != acc_reg);

    // Input sampling register; reset to blank so a steady input at reset
    // release must still fill a whole stability window.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            s_q_reg <= BLANK;
        end else begin
            s_q_reg <= seg;
        end
    end

    // Debounce: track the candidate pattern and how long it has been stable.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            cand_reg <= BLANK;
            cnt_reg  <= '0;
        end else if (s_q_reg != cand_reg) begin
            cand_reg <= s_q_reg;
            cnt_reg  <= '0;
        end else if (cnt_reg < CNT_LAST) begin
            cnt_reg  <= cnt_reg + 4'd1;
        end
    end

    // Acceptance and decode; uses this cycle's candidate even if the
    // candidate is being replaced on the same edge.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            acc_reg     <= BLANK;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= accept;
            if (accept) begin
                acc_reg <= cand_reg;
                if (glyph_hit) begin
                    data_reg  <= glyph_val;
                    valid_reg <= 1'b1;
                    err_reg   <= 1'b0;
                end else begin
                    valid_reg <= 1'b0;
                    err_reg   <= (cand_reg != BLANK);
                end
            end
        end
    end

    // Interval measurement between acceptances, saturating on long idles.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            gap_reg    <= '0;
            period_reg <= '0;
        end else if (accept) begin
            period_reg <= gap_reg;
            gap_reg    <= 28'd1;
        end else if (gap_reg != GAP_MAX) begin
            gap_reg    <= gap_reg + 28'd1;
        end
    end

    assign data    = data_reg;
    assign valid   = valid_reg;
    assign err     = err_reg;
    assign changed = changed_reg;
    assign period  = period_reg;

endmodule
